// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the CPU pipeline stage registers:
//   - stage_state_e : occupancy of a skid-buffered stage (EMPTY / ONE / TWO)
//   - <STAGE>_DATA_W / <STAGE>_CTRL_W : default bundle widths per pipeline boundary,
//     passed as parameter values when each stage register is instantiated
//   - CTRL_NOP : control value that marks a bubble
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    localparam int IF_ID_DATA_W  = 64;
    localparam int IF_ID_CTRL_W  = 2;
    localparam int ID_EX_DATA_W  = 165;
    localparam int ID_EX_CTRL_W  = 12;
    localparam int EX_MEM_DATA_W = 133;
    localparam int EX_MEM_CTRL_W = 5;
    localparam int MEM_WB_DATA_W = 70;
    localparam int MEM_WB_CTRL_W = 3;

    localparam int CTRL_NOP = 0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter for performance monitoring.
// Ports:
//   clk   in   clock, rising edge
//   reset in   asynchronous active-high reset (count -> 0)
//   inc   in   add one this cycle (ignored once the counter is all-ones)
//   clr   in   synchronous clear, wins over inc
//   count out  current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Flow-controlled pipeline stage register with a 2-entry skid buffer. in_ready
// depends only on the registered state, so downstream back-pressure never reaches
// upstream combinationally.
// Ports:
//   clk, reset              clock / asynchronous active-high reset
//   flush                   synchronous squash of all held beats
//   in_valid, in_ready      upstream handshake
//   data_in, ctr_in         upstream data / control bundles
//   out_valid, out_ready    downstream handshake
//   data_out, ctr_out       stage data / control (ctr_out is 0 while out_valid=0)
//   clr_stats               synchronous clear of stall_cycles
//   stall_cycles            saturating count of cycles with out_valid & !out_ready
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | no beat held, outputs show a bubble
// ONE   | main slot holds the beat on the outputs
// TWO   | main and skid slots full, in_ready low
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W              = EX_MEM_DATA_W,
    parameter int CTRL_W              = EX_MEM_CTRL_W,
    parameter int CNT_W               = 16,
    parameter bit ZERO_DATA_ON_BUBBLE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [CTRL_W-1:0] ctr_out,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  stall_cycles
);

    stage_state_e      r_state;
    stage_state_e      w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_in_ready  = (r_state != TWO);
    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = in_valid & w_in_ready;
    assign w_fire      = w_out_valid & out_ready;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state and slot load selects
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            // a beat accepted alongside a flush is dropped: no slot is loaded
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && !w_fire) begin
                        w_state_nxt = TWO;
                        w_load_skid = 1'b1;
                    end else if (w_accept && w_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (w_fire) begin
                        w_state_nxt      = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // outputs
    always_comb begin
        in_ready  = w_in_ready;
        out_valid = w_out_valid;
        ctr_out   = w_out_valid ? r_main_ctrl : CTRL_W'(CTRL_NOP);
        data_out  = (ZERO_DATA_ON_BUBBLE && !w_out_valid) ? '0 : r_main_data;
    end

    // Data slots keep their contents on flush; only the control slots are
    // cleared so a squashed beat can never look like a live instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= data_in;
                r_main_ctrl <= ctr_in;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= data_in;
                r_skid_ctrl <= ctr_in;
            end
        end
    end

    logic w_stall_inc;
    assign w_stall_inc = w_out_valid & ~out_ready;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .clr   (clr_stats),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Two instances share all stimulus: dut0 uses default widths (data held on bubble),
// dut1 uses a 16-bit data bundle, a 4-bit stall counter and zeroed data on bubble.
module tb_pipe_stage_reg;

    localparam int DW = 133;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [CW-1:0] ctr_in = '0;
    logic          out_ready = 1'b0;
    logic          clr_stats = 1'b0;

    logic          in_ready0, out_valid0;
    logic [DW-1:0] data_out0;
    logic [CW-1:0] ctr_out0;
    logic [15:0]   stall0;

    logic          in_ready1, out_valid1;
    logic [15:0]   data_out1;
    logic [CW-1:0] ctr_out1;
    logic [3:0]    stall1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .data_in(data_in), .ctr_in(ctr_in),
        .out_valid(out_valid0), .out_ready(out_ready),
        .data_out(data_out0), .ctr_out(ctr_out0),
        .clr_stats(clr_stats), .stall_cycles(stall0)
    );

    pipe_stage_reg #(
        .DATA_W(16), .CTRL_W(CW), .CNT_W(4), .ZERO_DATA_ON_BUBBLE(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .data_in(data_in[15:0]), .ctr_in(ctr_in),
        .out_valid(out_valid1), .out_ready(out_ready),
        .data_out(data_out1), .ctr_out(ctr_out1),
        .clr_stats(clr_stats), .stall_cycles(stall1)
    );

    // ---------------- reference model: bounded FIFO of capacity 2 ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t         q[$];
    int            m_stall = 0;
    int            m_stall4 = 0;
    logic [DW-1:0] m_last = '0;
    bit            m_vld, m_rdy, m_fire, m_acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_stall  = 0;
            m_stall4 = 0;
            m_last   = '0;
        end else begin
            m_vld  = (q.size() > 0);
            m_rdy  = (q.size() < 2);
            m_fire = m_vld && out_ready;
            m_acc  = in_valid && m_rdy;
            if (clr_stats) begin
                m_stall  = 0;
                m_stall4 = 0;
            end else if (m_vld && !out_ready) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall4 < 15) m_stall4++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (m_fire) void'(q.pop_front());
                if (m_acc) q.push_back('{d: data_in, c: ctr_in});
            end
            if (q.size() > 0) m_last = q[0].d;
        end
    end

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic          ev;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        ev = (q.size() > 0);
        ed = ev ? q[0].d : m_last;
        ec = ev ? q[0].c : '0;
        cmp("model_valid0", DW'(out_valid0), DW'(ev));
        cmp("model_ready0", DW'(in_ready0), DW'(q.size() < 2));
        cmp("model_ctr0", DW'(ctr_out0), DW'(ec));
        cmp("model_data0", data_out0, ed);
        cmp("model_stall0", DW'(stall0), DW'(m_stall));
        cmp("model_valid1", DW'(out_valid1), DW'(ev));
        cmp("model_ready1", DW'(in_ready1), DW'(q.size() < 2));
        cmp("model_ctr1", DW'(ctr_out1), DW'(ec));
        cmp("model_data1", DW'(data_out1), ev ? DW'(ed[15:0]) : '0);
        cmp("model_stall1", DW'(stall1), DW'(m_stall4));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid  = iv;
        out_ready = ordy;
        ctr_in    = c;
        data_in   = d;
    endtask

    // ---------------- directed table: back-pressure A,B,C then release ----------------
    typedef struct {
        logic        iv;
        logic        ordy;
        logic [4:0]  c;
        logic [15:0] d;
        logic        ev;
        logic        er;
        logic [4:0]  ec;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 5'd1, 16'h00A1, 1'b1, 1'b1, 5'd1, 16'h00A1};
        tbl[1] = '{1'b1, 1'b0, 5'd2, 16'h00B2, 1'b1, 1'b0, 5'd1, 16'h00A1};
        tbl[2] = '{1'b1, 1'b0, 5'd3, 16'h00C3, 1'b1, 1'b0, 5'd1, 16'h00A1};
        tbl[3] = '{1'b0, 1'b1, 5'd0, 16'h0000, 1'b1, 1'b1, 5'd2, 16'h00B2};
        tbl[4] = '{1'b0, 1'b1, 5'd0, 16'h0000, 1'b0, 1'b1, 5'd0, 16'h00B2};
        tbl[5] = '{1'b1, 1'b1, 5'd3, 16'h00C3, 1'b1, 1'b1, 5'd3, 16'h00C3};
        tbl[6] = '{1'b0, 1'b1, 5'd0, 16'h0000, 1'b0, 1'b1, 5'd0, 16'h00C3};

        // reset state
        reset = 1'b1;
        #1;
        cmp("rst_valid", DW'(out_valid0), '0);
        cmp("rst_ready", DW'(in_ready0), DW'(1));
        cmp("rst_ctr", DW'(ctr_out0), '0);
        cmp("rst_data", data_out0, '0);
        cmp("rst_stall", DW'(stall0), '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].c, DW'(tbl[i].d));
            step();
            cmp($sformatf("tbl%0d_valid", i), DW'(out_valid0), DW'(tbl[i].ev));
            cmp($sformatf("tbl%0d_ready", i), DW'(in_ready0), DW'(tbl[i].er));
            cmp($sformatf("tbl%0d_ctr", i), DW'(ctr_out0), DW'(tbl[i].ec));
            cmp($sformatf("tbl%0d_data0", i), data_out0, DW'(tbl[i].ed));
            cmp($sformatf("tbl%0d_data1", i), DW'(data_out1), tbl[i].ev ? DW'(tbl[i].ed) : '0);
        end

        // streaming at full rate
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b1, CW'(i), DW'(i));
            step();
            cmp("stream_valid", DW'(out_valid0), DW'(1));
            cmp("stream_ready", DW'(in_ready0), DW'(1));
            cmp("stream_ctr", DW'(ctr_out0), DW'(i));
            cmp("stream_data", data_out0, DW'(i));
        end
        drive(1'b0, 1'b1, '0, '0);
        step();
        cmp("stream_drained", DW'(out_valid0), '0);

        // flush from TWO with a concurrent in_valid
        drive(1'b1, 1'b0, 5'd4, DW'(4));
        step();
        drive(1'b1, 1'b0, 5'd5, DW'(5));
        step();
        cmp("flush_pre_ready", DW'(in_ready0), '0);
        drive(1'b1, 1'b0, 5'd6, DW'(6));
        flush = 1'b1;
        step();
        flush = 1'b0;
        cmp("flush_valid", DW'(out_valid0), '0);
        cmp("flush_ctr", DW'(ctr_out0), '0);
        cmp("flush_ready", DW'(in_ready0), DW'(1));
        cmp("flush_data_hold", data_out0, DW'(4));
        drive(1'b0, 1'b1, '0, '0);
        repeat (2) begin
            step();
            cmp("flush_no_ghost", DW'(out_valid0), '0);
        end

        // stall counter and saturation
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        drive(1'b1, 1'b0, 5'd1, DW'(9));
        step();
        drive(1'b0, 1'b0, '0, '0);
        repeat (10) step();
        cmp("stall_10", DW'(stall0), DW'(10));
        cmp("stall4_10", DW'(stall1), DW'(10));
        repeat (10) step();
        cmp("stall_20", DW'(stall0), DW'(20));
        cmp("stall4_sat", DW'(stall1), DW'(15));
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        cmp("stall_clr", DW'(stall0), '0);
        cmp("stall4_clr", DW'(stall1), '0);
        out_ready = 1'b1;
        step();

        // reset mid-stream from TWO
        drive(1'b1, 1'b0, 5'd1, DW'(1));
        step();
        drive(1'b1, 1'b0, 5'd2, DW'(2));
        step();
        #2;
        reset = 1'b1;
        #1;
        cmp("mrst_valid", DW'(out_valid0), '0);
        cmp("mrst_ctr", DW'(ctr_out0), '0);
        cmp("mrst_ready", DW'(in_ready0), DW'(1));
        cmp("mrst_stall", DW'(stall0), '0);
        cmp("mrst_data", data_out0, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b1, 5'd3, DW'(3));
        step();
        cmp("mrst_first_valid", DW'(out_valid0), DW'(1));
        cmp("mrst_first_data", data_out0, DW'(3));
        cmp("mrst_first_ctr", DW'(ctr_out0), DW'(3));
        drive(1'b0, 1'b1, '0, '0);
        step();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            clr_stats = ($urandom_range(0, 31) == 0);
            ctr_in    = CW'($urandom);
            data_in   = {$urandom, $urandom, $urandom, $urandom, 5'($urandom)};
            step();
        end
        flush = 1'b0;
        clr_stats = 1'b0;
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
